rs_syndrome_seq: RTL and testbench

Syndrome sequencer for the RS(16,8) decoder front end. It accepts 16 received symbols per block over a valid/ready stream and computes the 8 syndromes S_j = r(α^j), j = 0..7, over GF(256) with primitive polynomial 0x11d and α = 0x02. By default one combinational multiplier (`gf256mul_dec`) is shared across all 8 syndrome accumulators under FSM control. The 64-bit syndrome vector is handed to the key-equation stage over a second valid/ready handshake.

---
 rtl/rs_syndrome_seq.sv | 138 +++++++++++++
 tb/tb_rs_syndrome_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_seq.sv
// RS(16,8) syndrome sequencer: Horner accumulation of S_j = r(alpha^j) over GF(256)/0x11d.
// Default: one shared GF multiplier, 9 cycles/symbol. `define RS_SYND_PAR_EN for one multiplier per syndrome.
module gf256mul_dec (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_a;
  always_comb begin
    o_p = '0;
    w_a = i_a;
    for (int i = 0; i < 8; i++) begin
      if (i_b[i]) o_p = o_p ^ w_a;
      w_a = {w_a[6:0], 1'b0} ^ (w_a[7] ? 8'h1d : 8'h00);
    end
  end
endmodule

module rs_syndrome_seq #(
  parameter int N_SYM  = 16,
  parameter int N_SYND = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [7:0]          i_in_sym,
  output logic                o_synd_valid,
  input  logic                i_synd_ready,
  output logic [8*N_SYND-1:0] o_synd,
  output logic                o_synd_nz
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int SC_W = $clog2(N_SYM);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(N_SYM - 1);

  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < e; i++) p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1d : 8'h00);
    return p;
  endfunction

  logic [1:0]                  r_state;
  logic [SC_W-1:0]             r_sc;
  logic [N_SYND-1:0][7:0]      r_synd;
  logic [N_SYND-1:0][7:0]      w_alpha;

  for (genvar g = 0; g < N_SYND; g++) begin : g_alpha
    assign w_alpha[g] = alpha_pow(g);
  end

  assign o_in_ready   = (r_state == S_IDLE);
  assign o_synd_valid = (r_state == S_DONE);
  assign o_synd       = r_synd;
  assign o_synd_nz    = |r_synd;

`ifdef RS_SYND_PAR_EN
  logic [N_SYND-1:0][7:0] w_prod;

  for (genvar g = 0; g < N_SYND; g++) begin : g_mul
    gf256mul_dec u_mul (.i_a(r_synd[g]), .i_b(w_alpha[g]), .o_p(w_prod[g]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sc    <= '0;
      r_synd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          for (int j = 0; j < N_SYND; j++) r_synd[j] <= w_prod[j] ^ i_in_sym;
          if (r_sc == SC_LAST) begin
            r_sc    <= '0;
            r_state <= S_DONE;
          end else begin
            r_sc <= r_sc + 1'b1;
          end
        end
        S_DONE: if (i_synd_ready) begin
          r_synd  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  localparam int J_W = $clog2(N_SYND);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_SYND - 1);

  logic [J_W-1:0] r_j;
  logic [7:0]     r_sym;
  logic [7:0]     w_prod;

  // single multiplier time-shared across accumulators, index j selects operand and constant
  gf256mul_dec u_mul (.i_a(r_synd[r_j]), .i_b(w_alpha[r_j]), .o_p(w_prod));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sc    <= '0;
      r_j     <= '0;
      r_sym   <= '0;
      r_synd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          r_sym   <= i_in_sym;
          r_j     <= '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_synd[r_j] <= w_prod ^ r_sym;
          r_j         <= r_j + 1'b1;
          if (r_j == J_LAST) begin
            if (r_sc == SC_LAST) begin
              r_sc    <= '0;
              r_state <= S_DONE;
            end else begin
              r_sc    <= r_sc + 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: if (i_synd_ready) begin
          r_synd  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Scoreboard bench for rs_syndrome_seq: expected syndromes come from direct evaluation r(alpha^j).
module tb_rs_syndrome_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_sym = '0;
  logic        synd_valid;
  logic        synd_ready = 1'b0;
  logic [63:0] synd;
  logic        synd_nz;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_hs = 0;
  int t_first, t_valid;
  logic [7:0]  blk [16];
  logic [63:0] sb_q [$];

`ifdef RS_SYND_PAR_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 143;
`endif

  rs_syndrome_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_sym(in_sym),
    .o_synd_valid(synd_valid), .i_synd_ready(synd_ready),
    .o_synd(synd), .o_synd_nz(synd_nz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (synd_valid && synd_ready) n_hs <= n_hs + 1;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1d : 8'h00);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic logic [7:0] apow(input int e);
    logic [7:0] p = 8'h01;
    for (int i = 0; i < e; i++) p = gmul(p, 8'h02);
    return p;
  endfunction

  // blk[k] holds r_(15-k): S_j = XOR_k blk[k] * alpha^(j*(15-k))
  function automatic logic [63:0] model();
    logic [63:0] v = '0;
    for (int j = 0; j < 8; j++) begin
      logic [7:0] s = '0;
      for (int k = 0; k < 16; k++) s ^= gmul(blk[k], apow(j * (15 - k)));
      v[8*j +: 8] = s;
    end
    return v;
  endfunction

  task automatic send_sym(input logic [7:0] s);
    int t = 0;
    in_valid = 1'b1;
    in_sym   = s;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_chk++; n_fail++; $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t); end
    @(posedge clk); #1;
  endtask

  task automatic send_block();
    sb_q.push_back(model());
    for (int k = 0; k < 16; k++) begin
      send_sym(blk[k]);
      if (k == 0) t_first = cyc;
    end
  endtask

  task automatic wait_synd(input string nm);
    int t = 0;
    logic [63:0] exp;
    while (!synd_valid && t < 300) begin @(posedge clk); #1; t++; end
    t_valid = cyc;
    n_chk++;
    if (!synd_valid) begin n_fail++; $display("FAIL %s_valid_timeout: synd_valid never rose", nm); return; end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    n_chk++;
    if (synd !== exp) begin n_fail++; $display("FAIL %s_synd: got %h want %h", nm, synd, exp); end
    n_chk++;
    if (synd_nz !== (exp != 0)) begin n_fail++; $display("FAIL %s_nz: got %b want %b", nm, synd_nz, exp != 0); end
    synd_ready = 1'b1;
    @(posedge clk); #1;
    synd_ready = 1'b0;
    n_chk++;
    if (synd_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_handoff: valid=%b ready=%b want valid=0 ready=1", nm, synd_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({in_ready, synd_valid, synd, synd_nz} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b valid=%b synd=%h nz=%b want 1 0 0 0", in_ready, synd_valid, synd, synd_nz);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_block();
    foreach (blk[k]) blk[k] = 8'h00;
    send_block();
    wait_synd("zero");
    n_chk++;
    if (t_valid - t_first !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d edges want %0d", t_valid - t_first, LAT); end
  endtask

  task automatic test_last_err();
    foreach (blk[k]) blk[k] = 8'h00;
    blk[15] = 8'h05;
    send_block();
    n_chk++;
    if (sb_q[0] !== {8{8'h05}}) begin n_fail++; $display("FAIL last_model: got %h want all 05", sb_q[0]); end
    wait_synd("last_err");
  endtask

  task automatic test_first_err();
    foreach (blk[k]) blk[k] = 8'h00;
    blk[0] = 8'h01;
    send_block();
    while (!synd_valid && cyc < t_first + 300) begin @(posedge clk); #1; end
    n_chk++;
    if (synd[23:0] !== 24'h602601) begin n_fail++; $display("FAIL first_err_s012: got %h want 602601", synd[23:0]); end
    wait_synd("first_err");
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic        held_nz;
    int bad = 0;
    for (int k = 0; k < 16; k++) blk[k] = 8'(k * 17 + 3);
    send_block();
    while (!synd_valid && cyc < t_first + 300) begin @(posedge clk); #1; end
    held = synd; held_nz = synd_nz;
    in_sym = 8'hff;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if (synd !== held || synd_nz !== held_nz || synd_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; bad++;
        if (bad < 4) $display("FAIL bp_hold: cyc %0d synd=%h nz=%b valid=%b ready=%b want %h %b 1 0",
                              c, synd, synd_nz, synd_valid, in_ready, held, held_nz);
      end
    end
    wait_synd("backpressure");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) send_sym(8'(8'h31 + k));
    while (!in_ready) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, synd_valid, synd, synd_nz} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_outputs: ready=%b valid=%b synd=%h nz=%b want 1 0 0 0", in_ready, synd_valid, synd, synd_nz);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (blk[k]) blk[k] = 8'h00;
    blk[15] = 8'h05;
    send_block();
    wait_synd("after_reset");
  endtask

  task automatic test_back_to_back();
    int hs0 = n_hs;
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom_range(0, 255));
    send_block();
    wait_synd("b2b_a");
    for (int k = 0; k < 16; k++) blk[k] = 8'(8'ha5 ^ (k * 29));
    send_block();
    wait_synd("b2b_b");
    in_valid = 1'b0;
    n_chk++;
    if (n_hs - hs0 !== 2) begin n_fail++; $display("FAIL b2b_handshakes: got %0d want 2", n_hs - hs0); end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_last_err();
    test_first_err();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
